// File: rtl/dma_bus_arbiter.sv
// DMA bus arbiter: halts the CPU via ready and shares the master bus between DMC sample
// fetches and OAM DMA slots. All scheduling happens on CPU-cycle boundaries.
//
// state  | meaning
// IDLE   | CPU owns the bus, ready high
// HALT   | waiting for a CPU read cycle to stall on
// DUMMY  | CPU halted, dummy cycle ahead of a DMC fetch
// ALIGN  | extra cycle so the fetch lands on a get cycle
// DMC_RD | DMC sample read on the master bus
// OAM    | one OAM DMA slot (read RAM or write 0x2004)
`timescale 1ns/1ps
module dma_bus_arbiter #(
  parameter logic GET_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ph1_rising,
  input  logic        ph2_falling,
  input  logic        even_cycle,
  input  logic        cpu_rnw,
  output logic        ready,
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic        dmc_ack,
  output logic [7:0]  dmc_data,
  input  logic        oam_req,
  input  logic        oam_rnw,
  input  logic [15:0] oam_addr,
  input  logic [7:0]  oam_dout,
  output logic        oam_grant,
  output logic [7:0]  oam_rdata,
  output logic        mst_mem_rnw,
  output logic [15:0] mst_mem_address,
  output logic        mst_mem_avalid,
  output logic [7:0]  mst_mem_dout,
  input  logic [7:0]  mst_mem_din
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_HALT, ST_DUMMY, ST_ALIGN, ST_DMC_RD, ST_OAM
  } state_t;

  state_t      state_q, state_d;
  logic        ready_q;
  logic        bus_rnw_q, bus_rnw_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic        bus_avalid_q, bus_avalid_d;
  logic [7:0]  bus_dout_q, bus_dout_d;
  logic        dmc_ack_q;
  logic [7:0]  dmc_data_q;
  logic        oam_grant_q;
  logic [7:0]  oam_rdata_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (dmc_req || oam_req) state_d = ST_HALT;
      ST_HALT: begin
        // a CPU write cannot be stalled, so keep waiting for a read
        if (!cpu_rnw)     state_d = ST_HALT;
        else if (dmc_req) state_d = ST_DUMMY;
        else if (oam_req) state_d = ST_OAM;
        else              state_d = ST_IDLE;
      end
      ST_DUMMY:  state_d = ((~even_cycle) == GET_PARITY) ? ST_DMC_RD : ST_ALIGN;
      ST_ALIGN:  state_d = ST_DMC_RD;
      ST_DMC_RD: state_d = oam_req ? ST_OAM : ST_IDLE;
      ST_OAM: begin
        if (dmc_req)      state_d = ST_DUMMY;
        else if (oam_req) state_d = ST_OAM;
        else              state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_rnw_d    = 1'b1;
    bus_addr_d   = bus_addr_q;
    bus_avalid_d = 1'b0;
    bus_dout_d   = 8'h00;
    case (state_q)
      ST_OAM: begin
        bus_rnw_d    = oam_rnw;
        bus_addr_d   = oam_addr;
        bus_avalid_d = 1'b1;
        bus_dout_d   = oam_rnw ? 8'h00 : oam_dout;
      end
      ST_DMC_RD: begin
        bus_addr_d   = dmc_addr;
        bus_avalid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b1;
      bus_rnw_q    <= 1'b1;
      bus_addr_q   <= 16'h0000;
      bus_avalid_q <= 1'b0;
      bus_dout_q   <= 8'h00;
      dmc_ack_q    <= 1'b0;
      dmc_data_q   <= 8'h00;
      oam_grant_q  <= 1'b0;
      oam_rdata_q  <= 8'h00;
    end else begin
      dmc_ack_q   <= 1'b0;
      oam_grant_q <= 1'b0;
      if (ph1_rising) begin
        ready_q      <= (state_q == ST_IDLE);
        bus_rnw_q    <= bus_rnw_d;
        bus_addr_q   <= bus_addr_d;
        bus_avalid_q <= bus_avalid_d;
        bus_dout_q   <= bus_dout_d;
      end
      if (ph2_falling) begin
        state_q <= state_d;
        if (state_q == ST_DMC_RD) begin
          dmc_data_q <= mst_mem_din;
          dmc_ack_q  <= 1'b1;
        end
        if (state_q == ST_OAM) begin
          oam_grant_q <= 1'b1;
          if (bus_rnw_q) oam_rdata_q <= mst_mem_din;
        end
      end
    end
  end

  assign ready           = ready_q;
  assign dmc_ack         = dmc_ack_q;
  assign dmc_data        = dmc_data_q;
  assign oam_grant       = oam_grant_q;
  assign oam_rdata       = oam_rdata_q;
  assign mst_mem_rnw     = bus_rnw_q;
  assign mst_mem_address = bus_addr_q;
  assign mst_mem_avalid  = bus_avalid_q;
  assign mst_mem_dout    = bus_dout_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: CPU-cycle strobe driver, DMC/OAM requester models and a
// scoreboard of expected bus accesses, DMC bytes and OAM read data.
`timescale 1ns/1ps
module tb_dma_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ph1_rising = 1'b0;
  logic        ph2_falling = 1'b0;
  logic        even_cycle = 1'b0;
  logic        cpu_rnw = 1'b1;
  logic        ready;
  logic        dmc_req = 1'b0;
  logic [15:0] dmc_addr = 16'h0000;
  logic        dmc_ack;
  logic [7:0]  dmc_data;
  logic        oam_req = 1'b0;
  logic        oam_rnw = 1'b1;
  logic [15:0] oam_addr = 16'h0000;
  logic [7:0]  oam_dout = 8'h00;
  logic        oam_grant;
  logic [7:0]  oam_rdata;
  logic        mst_mem_rnw;
  logic [15:0] mst_mem_address;
  logic        mst_mem_avalid;
  logic [7:0]  mst_mem_dout;
  logic [7:0]  mst_mem_din;

  dma_bus_arbiter #(.GET_PARITY(1'b0)) dut (
    .clk(clk), .rst(rst), .ph1_rising(ph1_rising), .ph2_falling(ph2_falling),
    .even_cycle(even_cycle), .cpu_rnw(cpu_rnw), .ready(ready),
    .dmc_req(dmc_req), .dmc_addr(dmc_addr), .dmc_ack(dmc_ack), .dmc_data(dmc_data),
    .oam_req(oam_req), .oam_rnw(oam_rnw), .oam_addr(oam_addr), .oam_dout(oam_dout),
    .oam_grant(oam_grant), .oam_rdata(oam_rdata),
    .mst_mem_rnw(mst_mem_rnw), .mst_mem_address(mst_mem_address),
    .mst_mem_avalid(mst_mem_avalid), .mst_mem_dout(mst_mem_dout), .mst_mem_din(mst_mem_din)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_data(input logic [15:0] a);
    case (a)
      16'hC123: return 8'h5A;
      16'h0200: return 8'h11;
      16'h0201: return 8'h22;
      default:  return a[7:0] ^ a[15:8] ^ 8'hA5;
    endcase
  endfunction

  assign mst_mem_din = rd_data(mst_mem_address);

  typedef struct packed { logic rnw; logic [15:0] addr; logic [7:0] dout; } bus_t;
  typedef struct packed { logic rd; logic [7:0] data; } oam_exp_t;

  bus_t       exp_bus[$];
  logic [7:0] exp_dmc[$];
  oam_exp_t   exp_oam[$];
  bus_t       slots[$];

  int   n_cmp = 0, n_bad = 0;
  int   n_low, n_pre, n_acc, n_ack, n_gnt, n_stray;
  int   wr_cnt = 0;
  int   oam_idx = 0;
  logic last_ready = 1'b1;
  logic rst_on_dmc = 1'b0;
  logic [7:0] last_rd = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr_counts();
    n_low = 0; n_pre = 0; n_acc = 0; n_ack = 0; n_gnt = 0; n_stray = 0;
  endtask

  task automatic push_bus(input logic rnw, input logic [15:0] addr, input logic [7:0] dout);
    bus_t b;
    b.rnw = rnw; b.addr = addr; b.dout = dout;
    exp_bus.push_back(b);
  endtask

  // OAM engine: presents slot oam_idx; oam_req means it wants a slot after the current one
  task automatic oam_drive();
    oam_req = (oam_idx + 1 < slots.size());
    if (oam_idx < slots.size()) begin
      oam_rnw  = slots[oam_idx].rnw;
      oam_addr = slots[oam_idx].addr;
      oam_dout = slots[oam_idx].rnw ? 8'h00 : last_rd;
    end
  endtask

  task automatic oam_load(input bus_t s[$]);
    oam_exp_t e;
    logic [7:0] model_rd;
    slots = s; oam_idx = 0; last_rd = 8'h00; model_rd = 8'h00;
    foreach (s[i]) begin
      e.rd   = s[i].rnw;
      e.data = s[i].rnw ? rd_data(s[i].addr) : 8'h00;
      exp_oam.push_back(e);
    end
    oam_drive();
  endtask

  function automatic int pending();
    return exp_bus.size() + exp_dmc.size() + exp_oam.size() + (dmc_req ? 1 : 0)
         + (last_ready ? 0 : 1) + ((oam_idx < slots.size()) ? 1 : 0);
  endfunction

  task automatic cpu_cycle();
    bus_t     b;
    oam_exp_t o;
    cpu_rnw = (wr_cnt == 0);
    if (wr_cnt > 0) wr_cnt--;
    ph1_rising = 1'b1;
    @(negedge clk);
    ph1_rising = 1'b0;
    last_ready = ready;
    if (dmc_ack || oam_grant) n_stray++;
    if (!ready) begin
      n_low++;
      if (n_acc == 0 && !mst_mem_avalid) n_pre++;
    end
    if (mst_mem_avalid) begin
      n_acc++;
      if (exp_bus.size() == 0) check_val("bus_unexp", mst_mem_avalid, 1'b0);
      else begin
        b = exp_bus.pop_front();
        check_val("bus_rnw",  mst_mem_rnw, b.rnw);
        check_val("bus_addr", mst_mem_address, b.addr);
        check_val("bus_dout", mst_mem_dout, b.dout);
      end
      if (rst_on_dmc) rst = 1'b1;
    end
    @(negedge clk);
    ph2_falling = 1'b1;
    @(negedge clk);
    ph2_falling = 1'b0;
    if (dmc_ack) begin
      n_ack++;
      if (exp_dmc.size() == 0) check_val("dmc_unexp", dmc_ack, 1'b0);
      else check_val("dmc_data", dmc_data, exp_dmc.pop_front());
      dmc_req = 1'b0;
    end
    if (oam_grant) begin
      n_gnt++;
      if (exp_oam.size() == 0) check_val("oam_unexp", oam_grant, 1'b0);
      else begin
        o = exp_oam.pop_front();
        if (o.rd) check_val("oam_rdata", oam_rdata, o.data);
      end
      if (oam_rnw) last_rd = oam_rdata;
      oam_idx++;
      oam_drive();
    end
    even_cycle = ~even_cycle;
  endtask

  task automatic run_drain(input int budget, input string tag, input int dmc_at);
    logic raised;
    raised = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (dmc_at >= 0 && !raised && oam_idx == dmc_at) begin
        dmc_req = 1'b1;
        raised  = 1'b1;
      end
      cpu_cycle();
      if (pending() == 0) break;
    end
    if (pending() != 0) check_val({tag, "_timeout"}, pending(), 0);
  endtask

  task automatic dmc_start(input logic par, input logic [15:0] addr);
    if (even_cycle != par) cpu_cycle();
    dmc_addr = addr;
    push_bus(1'b1, addr, 8'h00);
    exp_dmc.push_back(rd_data(addr));
    dmc_req = 1'b1;
  endtask

  bus_t s4[$];
  bus_t s6[$];

  initial begin
    s4 = '{'{1'b1, 16'h0200, 8'h00}, '{1'b0, 16'h2004, 8'h00},
           '{1'b1, 16'h0201, 8'h00}, '{1'b0, 16'h2004, 8'h00}};
    s6 = '{'{1'b1, 16'h0300, 8'h00}, '{1'b0, 16'h2004, 8'h00}};

    repeat (3) @(negedge clk);
    check_val("rst_ready",  ready, 1'b1);
    check_val("rst_rnw",    mst_mem_rnw, 1'b1);
    check_val("rst_avalid", mst_mem_avalid, 1'b0);
    check_val("rst_addr",   mst_mem_address, 16'h0000);
    check_val("rst_pulses", {dmc_ack, oam_grant}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // idle
    clr_counts();
    repeat (20) cpu_cycle();
    check_val("t1_ready_low", n_low, 0);
    check_val("t1_access", n_acc, 0);
    check_val("t1_ack_gnt", n_ack + n_gnt, 0);

    // DMC without / with ALIGN
    clr_counts();
    dmc_start(1'b1, 16'hC123);
    cpu_cycle();
    run_drain(20, "t2a", -1);
    check_val("t2a_low", n_low, 3);
    check_val("t2a_pre", n_pre, 2);
    check_val("t2a_acc", n_acc, 1);
    check_val("t2a_ack", n_ack, 1);

    clr_counts();
    dmc_start(1'b0, 16'hC123);
    cpu_cycle();
    run_drain(20, "t2b", -1);
    check_val("t2b_low", n_low, 4);
    check_val("t2b_pre", n_pre, 3);
    check_val("t2b_acc", n_acc, 1);

    // CPU writing for 2 cycles stretches HALT
    clr_counts();
    dmc_start(1'b1, 16'h8040);
    cpu_cycle();
    wr_cnt = 2;
    run_drain(20, "t3", -1);
    check_val("t3_low", n_low, 5);
    check_val("t3_pre", n_pre, 4);
    check_val("t3_acc", n_acc, 1);

    // four OAM slots, writes carry the bytes just read
    clr_counts();
    push_bus(1'b1, 16'h0200, 8'h00);
    push_bus(1'b0, 16'h2004, 8'h11);
    push_bus(1'b1, 16'h0201, 8'h00);
    push_bus(1'b0, 16'h2004, 8'h22);
    oam_load(s4);
    cpu_cycle();
    run_drain(30, "t4", -1);
    check_val("t4_gnt", n_gnt, 4);
    check_val("t4_acc", n_acc, 4);
    check_val("t4_low", n_low, 5);
    check_val("t4_pre", n_pre, 1);

    // DMC fetch inserted during OAM slot 2
    clr_counts();
    dmc_addr = 16'h8040;
    push_bus(1'b1, 16'h0200, 8'h00);
    push_bus(1'b0, 16'h2004, 8'h11);
    push_bus(1'b1, 16'h8040, 8'h00);
    push_bus(1'b1, 16'h0201, 8'h00);
    push_bus(1'b0, 16'h2004, 8'h22);
    exp_dmc.push_back(rd_data(16'h8040));
    oam_load(s4);
    run_drain(40, "t5", 1);
    check_val("t5_gnt", n_gnt, 4);
    check_val("t5_acc", n_acc, 5);
    check_val("t5_ack", n_ack, 1);

    // simultaneous requests: DMC first
    clr_counts();
    dmc_start(1'b0, 16'hC123);
    push_bus(1'b1, 16'h0300, 8'h00);
    push_bus(1'b0, 16'h2004, rd_data(16'h0300));
    oam_load(s6);
    run_drain(30, "t6", -1);
    check_val("t6_gnt", n_gnt, 2);
    check_val("t6_acc", n_acc, 3);
    check_val("t6_ack", n_ack, 1);
    check_val("t6_stray", n_stray, 0);

    // reset during DMC_RD aborts the fetch
    clr_counts();
    dmc_addr = 16'h8040;
    push_bus(1'b1, 16'h8040, 8'h00);
    rst_on_dmc = 1'b1;
    dmc_req = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cpu_cycle();
      if (rst) break;
    end
    check_val("t6r_rst_seen", rst, 1'b1);
    check_val("t6r_ack", n_ack, 0);
    check_val("t6r_ready", ready, 1'b1);
    check_val("t6r_avalid", mst_mem_avalid, 1'b0);
    check_val("t6r_addr", mst_mem_address, 16'h0000);
    check_val("t6r_dmc_data", dmc_data, 8'h00);
    check_val("t6r_oam_rdata", oam_rdata, 8'h00);
    check_val("t6r_pulses", {dmc_ack, oam_grant}, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    rst_on_dmc = 1'b0;
    dmc_req = 1'b0;
    @(negedge clk);

    // requester re-requests after the abort
    clr_counts();
    dmc_start(1'b1, 16'h8040);
    cpu_cycle();
    run_drain(20, "t6re", -1);
    check_val("t6re_ack", n_ack, 1);
    check_val("t6re_low", n_low, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1);
  end

endmodule
